// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SRL/SRA/ROR/SLL): stage k shifts by 2^k, with valid/ready flow control and a tag carried alongside.
// Define SHIFTER_ROTATE_EN to build op 2'b10 as rotate right; without it, op 2'b10 returns the operand unchanged.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [$clog2(WIDTH)-1:0]   i_amount,
  input  logic [1:0]                 i_op,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_result,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SLL = 2'b11;

  logic [SH_W-1:0]  r_valid;
  logic [WIDTH-1:0] r_data [SH_W];
  logic [SH_W-1:0]  r_amt  [SH_W];
  logic [1:0]       r_op   [SH_W];
  logic [TAG_W-1:0] r_tag  [SH_W];

  logic [SH_W:0]    w_ready;
  logic [SH_W-1:0]  w_in_valid;
  logic [WIDTH-1:0] w_in_data [SH_W];
  logic [SH_W-1:0]  w_in_amt  [SH_W];
  logic [1:0]       w_in_op   [SH_W];
  logic [TAG_W-1:0] w_in_tag  [SH_W];
  logic [WIDTH-1:0] w_step    [SH_W];

  assign w_ready[SH_W] = i_ready;

  genvar gi;
  generate
    for (gi = 0; gi < SH_W; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      logic [WIDTH-1:0] w_shift;

      if (gi == 0) begin : g_first
        assign w_in_valid[gi] = i_valid;
        assign w_in_data[gi]  = i_data;
        assign w_in_amt[gi]   = i_amount;
        assign w_in_op[gi]    = i_op;
        assign w_in_tag[gi]   = i_tag;
      end else begin : g_rest
        assign w_in_valid[gi] = r_valid[gi-1];
        assign w_in_data[gi]  = r_data[gi-1];
        assign w_in_amt[gi]   = r_amt[gi-1];
        assign w_in_op[gi]    = r_op[gi-1];
        assign w_in_tag[gi]   = r_tag[gi-1];
      end

      // A stage may load when it is empty or its successor will take its contents.
      assign w_ready[gi] = !r_valid[gi] || w_ready[gi+1];

      // SRA keeps the MSB at every step, so each stage sees the original sign bit.
      always_comb begin
        w_shift = w_in_data[gi];
        if (w_in_amt[gi][gi]) begin
          case (w_in_op[gi])
            OP_SRL: w_shift = {{STEP{1'b0}}, w_in_data[gi][WIDTH-1:STEP]};
            OP_SRA: w_shift = {{STEP{w_in_data[gi][WIDTH-1]}}, w_in_data[gi][WIDTH-1:STEP]};
`ifdef SHIFTER_ROTATE_EN
            OP_ROR: w_shift = {w_in_data[gi][STEP-1:0], w_in_data[gi][WIDTH-1:STEP]};
`else
            OP_ROR: w_shift = w_in_data[gi];
`endif
            OP_SLL: w_shift = {w_in_data[gi][WIDTH-1-STEP:0], {STEP{1'b0}}};
            default: w_shift = w_in_data[gi];
          endcase
        end
      end

      assign w_step[gi] = w_shift;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < SH_W; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_op[k]   <= '0;
        r_tag[k]  <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < SH_W; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_in_valid[k];
          r_data[k]  <= w_step[k];
          r_amt[k]   <= w_in_amt[k];
          r_op[k]    <= w_in_op[k];
          r_tag[k]   <= w_in_tag[k];
        end
      end
    end
  end

  // The last stage's control fields have no consumer downstream.
  logic w_unused;
  assign w_unused = ^{r_amt[SH_W-1], r_op[SH_W-1]};

  assign o_ready  = w_ready[0] && !i_flush;
  assign o_valid  = r_valid[SH_W-1];
  assign o_result = r_data[SH_W-1];
  assign o_tag    = r_tag[SH_W-1];
  assign o_busy   = |r_valid;

endmodule
